// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Memory-side responder for the pipeline's data-memory port. It takes one
// load/store request at a time, waits LAT cycles, then performs the access
// against an internal word array and returns read data (or a store
// acknowledge) on a response channel. The CPU's memory stage can therefore
// run against a slow, stallable memory model.
//
// Handshake semantics (both channels): a transfer happens on a rising clk
// edge where valid and ready are both 1. The sender keeps valid and its
// payload stable until that edge; ready may change freely. Here req_ready_o
// is 1 only in IDLE, and resp_valid_o is 1 only in RESP, so a new request
// can never be accepted in the cycle a response is accepted.
//
// Parameters:
//   DEPTH  number of 32-bit words in the array (word index = addr[31:2])
//   LAT    wait cycles between request acceptance and response (0..15)
//
// Optional feature macro: DMEM_ERR_EN
//   defined   : misaligned addresses or word index >= DEPTH fault
//               (no write, rdata = 0, resp_err_o = 1)
//   undefined : addr[1:0] ignored, index wraps modulo DEPTH, resp_err_o = 0
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_ni        asynchronous active-low reset
//   req_valid_i   request present
//   req_ready_o   responder can accept a request this cycle
//   req_we_i      1 = store, 0 = load
//   req_addr_i    byte address
//   req_wdata_i   store data
//   resp_valid_o  response present
//   resp_ready_i  requester accepts the response
//   resp_rdata_o  load data; 0 for stores and errors
//   resp_err_o    access faulted
//   state_o       current FSM state (debug)
//
// The array has no reset; its contents survive rst_ni.
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH = 64,
  parameter int LAT   = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [1:0]  state_o
);

  localparam int          IW      = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [3:0]  LAT_W   = 4'(LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  // Access fields: with LAT=0 the access happens on the accept edge itself,
  // so it must use the live request; otherwise the latched copy.
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [31:0] word_full;
  logic [31:0] idx_full;
  logic [IW-1:0] idx;
  logic        acc_err;
  logic        do_access;
  logic        mem_we;
  logic        unused_bits;

  assign acc_we    = (LAT == 0) ? req_we_i    : we_q;
  assign acc_addr  = (LAT == 0) ? req_addr_i  : addr_q;
  assign acc_wdata = (LAT == 0) ? req_wdata_i : wdata_q;
  assign word_full = {2'b00, acc_addr[31:2]};

`ifdef DMEM_ERR_EN
  assign idx_full    = word_full;
  assign acc_err     = (acc_addr[1:0] != 2'b00) || (word_full >= DEPTH_W);
  assign unused_bits = ^idx_full[31:IW];
`else
  assign idx_full    = word_full % DEPTH_W;
  assign acc_err     = 1'b0;
  assign unused_bits = ^{idx_full[31:IW], acc_addr[1:0]};
`endif

  assign idx = idx_full[IW-1:0];

  // Next-state and response logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    do_access = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          if (LAT == 0) begin
            do_access = 1'b1;
            state_d   = S_RESP;
          end else begin
            cnt_d   = LAT_W;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          do_access = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready_i) begin
          rdata_d = 32'd0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (do_access) begin
      err_d   = acc_err;
      rdata_d = (acc_we || acc_err) ? 32'd0 : mem[idx];
    end
  end

  // A reset-aborted transaction never reaches do_access because the async
  // reset forces IDLE, so the unreset array cannot see a stray write.
  assign mem_we = do_access && acc_we && !acc_err;

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[idx] <= acc_wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];

  dmem_responder #(.DEPTH(64), .LAT(LAT)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err),
    .state_o      (state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present a request and hold it until accepted. Returns at #1
  // after the accepting edge with req_valid dropped and the request fields
  // scrambled, so the DUT must rely on its latched copy.
  task automatic send_req(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    logic acc;
    acc       = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (req_ready === 1'b1) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      bad++;
      $display("FAIL accept_timeout addr=%h: req_ready never 1 within 20 cycles", addr);
    end
    req_valid = 1'b0;
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  // Driver/monitor: raise resp_ready, wait (bounded) for resp_valid, capture
  // the response, step past the accepting edge.
  task automatic collect_resp(output logic [31:0] rd, output logic er,
                              output int waited, output logic rr_during,
                              output logic v_after, output logic r_after);
    resp_ready = 1'b1;
    waited     = 0;
    while (resp_valid !== 1'b1 && waited < 30) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (resp_valid !== 1'b1) begin
      bad++;
      $display("FAIL resp_timeout: resp_valid never 1 within 30 cycles");
    end
    rd        = resp_rdata;
    er        = resp_err;
    rr_during = req_ready;
    @(posedge clk);
    #1;
    v_after    = resp_valid;
    r_after    = req_ready;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    total++; if (resp_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", resp_err); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_store();
    logic [31:0] rd; logic er, rr, va, ra; int w;
    send_req(1'b1, 32'h10, 32'hDEADBEEF);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL store_ready_after_accept got=%b exp=0", req_ready); end
    collect_resp(rd, er, w, rr, va, ra);
    total++; if (w !== LAT) begin bad++; $display("FAIL store_latency got=%0d exp=%0d", w, LAT); end
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL store_rdata got=%h exp=0", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL store_err got=%b exp=0", er); end
    total++; if (rr !== 1'b0) begin bad++; $display("FAIL store_ready_in_resp got=%b exp=0", rr); end
    total++; if (va !== 1'b0) begin bad++; $display("FAIL store_one_cycle_valid got=%b exp=0", va); end
    total++; if (ra !== 1'b1) begin bad++; $display("FAIL store_ready_back got=%b exp=1", ra); end
  endtask

  task automatic test_raw();
    logic [31:0] rd; logic er, rr, va, ra; int w;
    send_req(1'b0, 32'h10, 32'h0);
    collect_resp(rd, er, w, rr, va, ra);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL raw_rdata got=%h exp=deadbeef", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL raw_err got=%b exp=0", er); end
  endtask

  task automatic test_backpressure();
    int w;
    resp_ready = 1'b0;
    send_req(1'b0, 32'h10, 32'h0);
    w = 0;
    while (resp_valid !== 1'b1 && w < 30) begin
      @(posedge clk);
      #1;
      w++;
    end
    // A competing store held on the request side must be ignored.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h10;
    req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, resp_valid); end
      total++; if (resp_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL bp_rdata cyc=%0d got=%h exp=deadbeef", i, resp_rdata); end
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_req_ready cyc=%0d got=%b exp=0", i, req_ready); end
      @(posedge clk);
      #1;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_cleared got=%b exp=0", resp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b exp=1", req_ready); end
    total++; if (resp_rdata !== 32'd0) begin bad++; $display("FAIL bp_rdata_cleared got=%h exp=0", resp_rdata); end
  endtask

  task automatic test_boundary();
    logic [31:0] rd; logic er, rr, va, ra; int w;
    logic [31:0] exp0;
    logic        exp_err;
    send_req(1'b1, 32'h0, 32'hA5A5A5A5);
    collect_resp(rd, er, w, rr, va, ra);
    send_req(1'b1, 32'hFC, 32'h12345678);
    collect_resp(rd, er, w, rr, va, ra);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL bnd_idx63_err got=%b exp=0", er); end
    send_req(1'b1, 32'h100, 32'h12345678);
    collect_resp(rd, er, w, rr, va, ra);
`ifdef DMEM_ERR_EN
    exp_err = 1'b1;
    exp0    = 32'hA5A5A5A5;
`else
    exp_err = 1'b0;
    exp0    = 32'h12345678;
`endif
    total++; if (er !== exp_err) begin bad++; $display("FAIL bnd_idx64_err got=%b exp=%b", er, exp_err); end
    total++; if (rd !== 32'd0) begin bad++; $display("FAIL bnd_idx64_rdata got=%h exp=0", rd); end
    send_req(1'b0, 32'h0, 32'h0);
    collect_resp(rd, er, w, rr, va, ra);
    total++; if (rd !== exp0) begin bad++; $display("FAIL bnd_load0 got=%h exp=%h", rd, exp0); end
    send_req(1'b0, 32'hFC, 32'h0);
    collect_resp(rd, er, w, rr, va, ra);
    total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL bnd_load63 got=%h exp=12345678", rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic er, rr, va, ra; int w;
    logic [31:0] exp_rd;
    logic        exp_err;
    send_req(1'b1, 32'h0, 32'h0F0F0F0F);
    collect_resp(rd, er, w, rr, va, ra);
    send_req(1'b0, 32'h2, 32'h0);
    collect_resp(rd, er, w, rr, va, ra);
`ifdef DMEM_ERR_EN
    exp_err = 1'b1;
    exp_rd  = 32'd0;
`else
    exp_err = 1'b0;
    exp_rd  = 32'h0F0F0F0F;
`endif
    total++; if (er !== exp_err) begin bad++; $display("FAIL mis_err got=%b exp=%b", er, exp_err); end
    total++; if (rd !== exp_rd) begin bad++; $display("FAIL mis_rdata got=%h exp=%h", rd, exp_rd); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er, rr, va, ra; int w;
    int seen;
    send_req(1'b1, 32'h20, 32'hCAFEF00D);
    collect_resp(rd, er, w, rr, va, ra);
    send_req(1'b1, 32'h20, 32'h0BADBEEF);
    rst_n = 1'b0;
    #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b exp=0", resp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b exp=1", req_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    resp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid === 1'b1) seen++;
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b0;
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_resp got=%0d exp=0", seen); end
    send_req(1'b0, 32'h20, 32'h0);
    collect_resp(rd, er, w, rr, va, ra);
    total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL abort_old_data got=%h exp=cafef00d", rd); end
  endtask

  task automatic test_back_to_back();
    int accepts;
    int first_c, second_c;
    logic acc;
    logic [31:0] e;
    accepts    = 0;
    first_c    = -1;
    second_c   = -1;
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_wdata  = 32'h0;
    req_addr   = 32'h10;
    for (int c = 0; c < 30; c++) begin
      if (c == 20) req_valid = 1'b0;
      if (resp_valid === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFFFFFF;
        total++; if (resp_rdata !== e) begin bad++; $display("FAIL b2b_rdata cyc=%0d got=%h exp=%h", c, resp_rdata, e); end
      end
      acc = (req_valid === 1'b1) && (req_ready === 1'b1);
      if (acc) begin
        exp_q.push_back((req_addr == 32'h10) ? 32'hDEADBEEF : 32'h12345678);
        if (first_c < 0) first_c = c;
        else if (second_c < 0) second_c = c;
        accepts++;
      end
      @(posedge clk);
      #1;
      if (acc) req_addr = (req_addr == 32'h10) ? 32'hFC : 32'h10;
    end
    resp_ready = 1'b0;
    total++; if (second_c - first_c !== LAT + 2) begin bad++; $display("FAIL b2b_turnaround got=%0d exp=%0d", second_c - first_c, LAT + 2); end
    total++; if (accepts !== 5) begin bad++; $display("FAIL b2b_accepts got=%0d exp=5", accepts); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL b2b_drain got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;
    test_reset();
    test_store();
    test_raw();
    test_backpressure();
    test_boundary();
    test_misaligned();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
